// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode
//
// A small RV32I-style fetch / decode front end. It fetches one instruction
// word, spends exactly one EXEC cycle presenting the decoded ALU op and its
// operands, and then writes the externally computed result back to the
// register file. An undecodable word parks the block in HALT until reset.
//
// Build option:
//   MISALIGN_TRAP_EN - when defined, a taken JAL/JALR/branch whose target has
//                      bit 1 set enters HALT. The register write and PC update
//                      for that instruction are dropped. When undefined, the
//                      computed target is used as is.
//
// Ports:
//   clk     in   1   sole clock, rising edge
//   reset   in   1   asynchronous, active-high
//   iaddr   out  32  instruction fetch address (PC)
//   idata   in   32  instruction word from imem
//   ivalid  in   1   idata valid this cycle
//   instr   out  32  latched instruction
//   op      out  6   ALU op code (63 outside EXEC or when undecodable)
//   rv1     out  32  operand 1, reg[rs1]
//   rv2     out  32  operand 2, I-immediate or reg[rs2]
//   daddr   out  32  load/store address
//   rvout   in   32  ALU result for writeback
//   exec    out  1   high during EXEC
//   halted  out  1   high in HALT
// ---------------------------------------------------------------------------
module fetch_decode (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        ivalid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] rv1,
    output logic [31:0] rv2,
    output logic [31:0] daddr,
    input  logic [31:0] rvout,
    output logic        exec,
    output logic        halted
);

    // ALU op codes
    localparam logic [5:0] OP_ADDI  = 6'd0;
    localparam logic [5:0] OP_SLTI  = 6'd1;
    localparam logic [5:0] OP_SLTIU = 6'd2;
    localparam logic [5:0] OP_XORI  = 6'd3;
    localparam logic [5:0] OP_ORI   = 6'd4;
    localparam logic [5:0] OP_ANDI  = 6'd5;
    localparam logic [5:0] OP_SLLI  = 6'd6;
    localparam logic [5:0] OP_SRLI  = 6'd7;
    localparam logic [5:0] OP_SRAI  = 6'd8;
    localparam logic [5:0] OP_ADD   = 6'd9;
    localparam logic [5:0] OP_SUB   = 6'd10;
    localparam logic [5:0] OP_SLL   = 6'd11;
    localparam logic [5:0] OP_SLT   = 6'd12;
    localparam logic [5:0] OP_SLTU  = 6'd13;
    localparam logic [5:0] OP_XOR   = 6'd14;
    localparam logic [5:0] OP_SRL   = 6'd15;
    localparam logic [5:0] OP_SRA   = 6'd16;
    localparam logic [5:0] OP_OR    = 6'd17;
    localparam logic [5:0] OP_AND   = 6'd18;
    localparam logic [5:0] OP_LB    = 6'd19;
    localparam logic [5:0] OP_LH    = 6'd20;
    localparam logic [5:0] OP_LW    = 6'd21;
    localparam logic [5:0] OP_LBU   = 6'd22;
    localparam logic [5:0] OP_LHU   = 6'd23;
    localparam logic [5:0] OP_SB    = 6'd24;
    localparam logic [5:0] OP_SH    = 6'd25;
    localparam logic [5:0] OP_SW    = 6'd26;
    localparam logic [5:0] OP_LUI   = 6'd27;
    localparam logic [5:0] OP_AUIPC = 6'd28;
    localparam logic [5:0] OP_JAL   = 6'd29;
    localparam logic [5:0] OP_JALR  = 6'd30;
    localparam logic [5:0] OP_BEQ   = 6'd31;
    localparam logic [5:0] OP_BNE   = 6'd32;
    localparam logic [5:0] OP_BLT   = 6'd33;
    localparam logic [5:0] OP_BGE   = 6'd34;
    localparam logic [5:0] OP_BLTU  = 6'd35;
    localparam logic [5:0] OP_BGEU  = 6'd36;
    localparam logic [5:0] OP_BAD   = 6'd63;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        exec_reg;
    logic        halted_reg;

    logic [31:0] regs [32];

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;

    logic [5:0]  dec_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        br_taken;
    logic        redirect;
    logic [31:0] target;
    logic        trap;
    logic        writes_rd;
    logic        wr_en;
    logic        in_exec;
    logic [31:0] daddr_calc;

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign funct7 = instr_reg[31:25];
    assign rs1    = instr_reg[19:15];
    assign rs2    = instr_reg[24:20];
    assign rd     = instr_reg[11:7];

    assign imm_i = {{20{instr_reg[31]}}, instr_reg[31:20]};
    assign imm_s = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
    assign imm_b = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                    instr_reg[30:25], instr_reg[11:8], 1'b0};
    assign imm_j = {{11{instr_reg[31]}}, instr_reg[31], instr_reg[19:12],
                    instr_reg[20], instr_reg[30:21], 1'b0};

    // x0 is never written, so a plain array read returns 0 for it
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    always_comb begin
        dec_op = OP_BAD;
        case (opcode)
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_op = OP_ADDI;
                    3'b010:  dec_op = OP_SLTI;
                    3'b011:  dec_op = OP_SLTIU;
                    3'b100:  dec_op = OP_XORI;
                    3'b110:  dec_op = OP_ORI;
                    3'b111:  dec_op = OP_ANDI;
                    3'b001:  if (funct7 == 7'b0000000) dec_op = OP_SLLI;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec_op = OP_SRLI;
                        else if (funct7 == 7'b0100000) dec_op = OP_SRAI;
                    end
                    default: dec_op = OP_BAD;
                endcase
            end
            7'b0110011: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_op = OP_ADD;
                    {7'b0100000, 3'b000}: dec_op = OP_SUB;
                    {7'b0000000, 3'b001}: dec_op = OP_SLL;
                    {7'b0000000, 3'b010}: dec_op = OP_SLT;
                    {7'b0000000, 3'b011}: dec_op = OP_SLTU;
                    {7'b0000000, 3'b100}: dec_op = OP_XOR;
                    {7'b0000000, 3'b101}: dec_op = OP_SRL;
                    {7'b0100000, 3'b101}: dec_op = OP_SRA;
                    {7'b0000000, 3'b110}: dec_op = OP_OR;
                    {7'b0000000, 3'b111}: dec_op = OP_AND;
                    default:              dec_op = OP_BAD;
                endcase
            end
            7'b0000011: begin
                case (funct3)
                    3'b000:  dec_op = OP_LB;
                    3'b001:  dec_op = OP_LH;
                    3'b010:  dec_op = OP_LW;
                    3'b100:  dec_op = OP_LBU;
                    3'b101:  dec_op = OP_LHU;
                    default: dec_op = OP_BAD;
                endcase
            end
            7'b0100011: begin
                case (funct3)
                    3'b000:  dec_op = OP_SB;
                    3'b001:  dec_op = OP_SH;
                    3'b010:  dec_op = OP_SW;
                    default: dec_op = OP_BAD;
                endcase
            end
            7'b0110111: dec_op = OP_LUI;
            7'b0010111: dec_op = OP_AUIPC;
            7'b1101111: dec_op = OP_JAL;
            7'b1100111: if (funct3 == 3'b000) dec_op = OP_JALR;
            7'b1100011: begin
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_BLT;
                    3'b101:  dec_op = OP_BGE;
                    3'b110:  dec_op = OP_BLTU;
                    3'b111:  dec_op = OP_BGEU;
                    default: dec_op = OP_BAD;
                endcase
            end
            default: dec_op = OP_BAD;
        endcase
    end

    // -----------------------------------------------------------------------
    // Branch resolution and next-PC selection
    // -----------------------------------------------------------------------
    always_comb begin
        br_taken = 1'b0;
        case (dec_op)
            OP_BEQ:  br_taken = (rs1_val == rs2_val);
            OP_BNE:  br_taken = (rs1_val != rs2_val);
            OP_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            OP_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            OP_BLTU: br_taken = (rs1_val <  rs2_val);
            OP_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        redirect = 1'b0;
        target   = pc_reg + 32'd4;
        if (dec_op == OP_JAL) begin
            redirect = 1'b1;
            target   = pc_reg + imm_j;
        end else if (dec_op == OP_JALR) begin
            redirect = 1'b1;
            target   = (rs1_val + imm_i) & ~32'd1;
        end else if (br_taken) begin
            redirect = 1'b1;
            target   = pc_reg + imm_b;
        end
    end

    // Bit 0 of every target is already clear, so only bit 1 can misalign
    assign trap = TRAP_EN & redirect & target[1];

    // Stores, branches and the undecodable op leave the register file alone
    assign writes_rd = (dec_op <= OP_LHU) ||
                       ((dec_op >= OP_LUI) && (dec_op <= OP_JALR));

    assign in_exec = (state_reg == ST_EXEC);
    assign wr_en   = in_exec && writes_rd && !trap && (rd != 5'd0);

    always_comb begin
        daddr_calc = 32'd0;
        if ((dec_op >= OP_LB) && (dec_op <= OP_LHU))
            daddr_calc = rs1_val + imm_i;
        else if ((dec_op >= OP_SB) && (dec_op <= OP_SW))
            daddr_calc = rs1_val + imm_s;
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_FETCH;
            pc_reg     <= 32'd0;
            instr_reg  <= NOP_WORD;
            exec_reg   <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (ivalid) begin
                        instr_reg <= idata;
                        state_reg <= ST_EXEC;
                        exec_reg  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    exec_reg <= 1'b0;
                    if ((dec_op == OP_BAD) || trap) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        pc_reg    <= target;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= ST_FETCH;
                    exec_reg   <= 1'b0;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register file: 32 x 32, two combinational reads, one write
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[rd] <= rvout;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign iaddr  = pc_reg;
    assign instr  = instr_reg;
    assign exec   = exec_reg;
    assign halted = halted_reg;

    assign op    = in_exec ? dec_op  : OP_BAD;
    assign rv1   = in_exec ? rs1_val : 32'd0;
    // I-format ALU ops take the immediate as their second operand
    assign rv2   = in_exec ? ((dec_op <= OP_SRAI) ? imm_i : rs2_val) : 32'd0;
    assign daddr = in_exec ? daddr_calc : 32'd0;

endmodule

// File: tb/tb_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode
//
// Directed bench for fetch_decode. An instruction-level reference model
// (mask/match decode table, architectural PC and register array) predicts
// every output; a negedge process compares the DUT against it each cycle.
// Hand-computed literal checks at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_fetch_decode;

    logic        clk;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        ivalid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [31:0] daddr;
    logic [31:0] rvout;
    logic        exec;
    logic        halted;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    fetch_decode dut (
        .clk    (clk),
        .reset  (reset),
        .iaddr  (iaddr),
        .idata  (idata),
        .ivalid (ivalid),
        .instr  (instr),
        .op     (op),
        .rv1    (rv1),
        .rv2    (rv2),
        .daddr  (daddr),
        .rvout  (rvout),
        .exec   (exec),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Op n is the index of the first table row whose mask/match hits.
    localparam logic [31:0] DMASK [37] = '{
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000007F, 32'h0000007F, 32'h0000007F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F};
    localparam logic [31:0] DMATCH [37] = '{
        32'h00000013, 32'h00002013, 32'h00003013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00003033,
        32'h00004033, 32'h00005033, 32'h40005033, 32'h00006033, 32'h00007033,
        32'h00000003, 32'h00001003, 32'h00002003, 32'h00004003, 32'h00005003,
        32'h00000023, 32'h00001023, 32'h00002023,
        32'h00000037, 32'h00000017, 32'h0000006F, 32'h00000067,
        32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063, 32'h00006063, 32'h00007063};

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_mode;  // 0 fetch, 1 exec, 2 halt
    logic [31:0] m_regs [32];

    function automatic int m_op(input logic [31:0] w);
        for (int i = 0; i < 37; i++) begin
            if ((w & DMASK[i]) == DMATCH[i]) return i;
        end
        return 63;
    endfunction

    function automatic logic [31:0] m_immi(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] m_imms(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] m_immb(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] m_immj(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic bit m_taken(input int o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            31: return a == b;
            32: return a != b;
            33: return $signed(a) <  $signed(b);
            34: return $signed(a) >= $signed(b);
            35: return a <  b;
            36: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_redirect(input logic [31:0] w);
        int o = m_op(w);
        return (o == 29) || (o == 30) || m_taken(o, m_regs[w[19:15]], m_regs[w[24:20]]);
    endfunction

    function automatic logic [31:0] m_next_pc(input logic [31:0] pc, input logic [31:0] w);
        int o = m_op(w);
        if (o == 29) return pc + m_immj(w);
        if (o == 30) return (m_regs[w[19:15]] + m_immi(w)) & 32'hFFFF_FFFE;
        if (m_taken(o, m_regs[w[19:15]], m_regs[w[24:20]])) return pc + m_immb(w);
        return pc + 32'd4;
    endfunction

    function automatic bit m_misaligned(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] t = m_next_pc(pc, w);
        return TRAP && m_redirect(w) && t[1];
    endfunction

    function automatic bit m_writes(input int o);
        return (o <= 23) || ((o >= 27) && (o <= 30));
    endfunction

    function automatic logic [31:0] m_rv2(input logic [31:0] w);
        return (m_op(w) <= 8) ? m_immi(w) : m_regs[w[24:20]];
    endfunction

    function automatic logic [31:0] m_daddr(input logic [31:0] w);
        int o = m_op(w);
        if (o >= 19 && o <= 23) return m_regs[w[19:15]] + m_immi(w);
        if (o >= 24 && o <= 26) return m_regs[w[19:15]] + m_imms(w);
        return 32'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    <= 32'd0;
            m_mode  <= 0;
            m_instr <= 32'h0000_0013;
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
        end else if (m_mode == 0) begin
            if (ivalid) begin
                m_instr <= idata;
                m_mode  <= 1;
            end
        end else if (m_mode == 1) begin
            if (m_op(m_instr) == 63 || m_misaligned(m_pc, m_instr)) begin
                m_mode <= 2;
            end else begin
                m_pc   <= m_next_pc(m_pc, m_instr);
                m_mode <= 0;
                if (m_writes(m_op(m_instr)) && m_instr[11:7] != 5'd0)
                    m_regs[m_instr[11:7]] <= rvout;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("iaddr",  iaddr, m_pc);
        check("instr",  instr, m_instr);
        check("exec",   {31'd0, exec},   {31'd0, (m_mode == 1)});
        check("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
        if (m_mode == 1) begin
            check("op",    {26'd0, op}, 32'(m_op(m_instr)));
            check("rv1",   rv1,   m_regs[m_instr[19:15]]);
            check("rv2",   rv2,   m_rv2(m_instr));
            check("daddr", daddr, m_daddr(m_instr));
        end else begin
            check("op_idle",    {26'd0, op}, 32'd63);
            check("rv1_idle",   rv1,   32'd0);
            check("rv2_idle",   rv2,   32'd0);
            check("daddr_idle", daddr, 32'd0);
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word while in FETCH; returns in the EXEC cycle
    task automatic start(input logic [31:0] w, input logic [31:0] rv);
        $display("txn pc=%08h instr=%08h rvout=%08h", iaddr, w, rv);
        ivalid = 1'b1;
        idata  = w;
        rvout  = rv;
        tick();
        ivalid = 1'b0;
        idata  = 32'd0;
    endtask

    task automatic finish_instr();
        tick();
        rvout = 32'd0;
    endtask

    task automatic run(input logic [31:0] w, input logic [31:0] rv);
        start(w, rv);
        finish_instr();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("lit_iaddr_after_reset", iaddr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        ivalid = 1'b0;
        idata  = 32'd0;
        rvout  = 32'd0;
        repeat (2) tick();
        check("lit_reset_instr",  instr, 32'h0000_0013);
        check("lit_reset_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        check("lit_first_iaddr", iaddr, 32'd0);

        // ivalid low for three cycles: FETCH held, address stable
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_idle_iaddr", iaddr, 32'd0);
            check("lit_idle_exec",  {31'd0, exec}, 32'd0);
        end

        // ADDI x1,x0,5
        start(32'h0050_0093, 32'd5);
        check("lit_addi_exec", {31'd0, exec}, 32'd1);
        check("lit_addi_op",   {26'd0, op}, 32'd0);
        check("lit_addi_rv1",  rv1, 32'd0);
        check("lit_addi_rv2",  rv2, 32'd5);
        finish_instr();
        check("lit_addi_iaddr", iaddr, 32'd4);
        check("lit_addi_exec_drop", {31'd0, exec}, 32'd0);
        // ADD x5,x1,x0 reads back x1
        start(enc_r(0, 0, 1, 0, 5), 32'd5);
        check("lit_x1_value", rv1, 32'd5);
        finish_instr();

        // BEQ x1,x2,+16 at PC=8 with x1=x2=7
        do_reset();
        run(32'h0070_0093, 32'd7);
        run(32'h0070_0113, 32'd7);
        check("lit_pc_before_beq", iaddr, 32'd8);
        run(32'h0020_8863, 32'h999);
        check("lit_beq_target", iaddr, 32'd24);
        do_reset();
        run(32'h0070_0093, 32'd7);
        run(32'h0070_0113, 32'd7);
        run(32'h0020_9863, 32'h999);
        check("lit_bne_fallthrough", iaddr, 32'd12);

        // Store, x0 write, and general coverage through the model
        do_reset();
        run(enc_i(256, 0, 0, 1, 7'h13), 32'h100);
        run(enc_i(85, 0, 0, 2, 7'h13), 32'h55);
        start(32'hFE20_AE23, 32'hDEAD);   // SW x2,-4(x1)
        check("lit_sw_op",    {26'd0, op}, 32'd26);
        check("lit_sw_daddr", daddr, 32'h0000_00FC);
        check("lit_sw_rv2",   rv2,   32'h55);
        finish_instr();
        run(enc_r(0, 2, 1, 0, 0), 32'h155);           // ADD x0,x1,x2
        start(enc_r(0, 28, 0, 0, 6), 32'd0);          // ADD x6,x0,x28
        check("lit_x0_reads_zero", rv1, 32'd0);
        check("lit_sw_no_write",   rv2, 32'd0);
        finish_instr();
        run(enc_i(-1, 0, 0, 10, 7'h13), 32'hFFFF_FFFF); // ADDI x10,x0,-1
        run(enc_r(32, 2, 1, 0, 11), 32'hAB);            // SUB
        run(enc_r(0, 1, 10, 3, 12), 32'd0);             // SLTU
        start(enc_i(8, 1, 2, 7, 7'h03), 32'h77);        // LW x7,8(x1)
        check("lit_lw_op",    {26'd0, op}, 32'd21);
        check("lit_lw_daddr", daddr, 32'h108);
        finish_instr();
        run(enc_b(8, 1, 10, 4), 32'd0);    // BLT  x10,x1  taken
        run(enc_b(8, 1, 10, 6), 32'd0);    // BLTU x10,x1  not taken
        run(enc_b(-8, 10, 1, 5), 32'd0);   // BGE  x1,x10  taken backwards
        run(enc_b(12, 10, 1, 7), 32'd0);   // BGEU x1,x10  not taken
        run(32'h1234_56B7, 32'h1234_5000); // LUI x13
        run(32'h0000_1717, 32'h4444);      // AUIPC x14
        run(enc_j(8, 8), 32'h8888);        // JAL x8,+8
        run(enc_i(3, 1, 0, 9, 7'h67), 32'h1234); // JALR x9,3(x1) -> 0x102
`ifdef MISALIGN_TRAP_EN
        check("lit_jalr_trap", {31'd0, halted}, 32'd1);
`else
        check("lit_jalr_target", iaddr, 32'h102);
`endif

        // PC wrap: jump to 0xFFFFFFFC, then step past the top
        do_reset();
        run(enc_i(-1, 0, 0, 10, 7'h13), 32'hFFFF_FFFF);
        run(enc_i(-3, 10, 0, 0, 7'h67), 32'd0);
        check("lit_wrap_top", iaddr, 32'hFFFF_FFFC);
        run(32'h0000_0013, 32'd0);
        check("lit_wrap_zero", iaddr, 32'd0);

        // Reset during EXEC of ADDI x3,x0,9
        do_reset();
        start(32'h0090_0193, 32'd9);
        reset = 1'b1;
        #1;
        check("lit_midexec_exec", {31'd0, exec}, 32'd0);
        check("lit_midexec_iaddr", iaddr, 32'd0);
        tick();
        reset = 1'b0;
        rvout = 32'd0;
        check("lit_release_iaddr", iaddr, 32'd0);
        start(enc_r(0, 0, 3, 0, 4), 32'd0);  // ADD x4,x3,x0
        check("lit_x3_suppressed", rv1, 32'd0);
        finish_instr();

        // Undecodable word halts with PC frozen
        start(32'hFFFF_FFFF, 32'd0);
        check("lit_bad_op", {26'd0, op}, 32'd63);
        finish_instr();
        ivalid = 1'b1;
        idata  = 32'h0050_0093;
        for (int i = 0; i < 4; i++) begin
            check("lit_halt_flag",  {31'd0, halted}, 32'd1);
            check("lit_halt_iaddr", iaddr, 32'd4);
            tick();
        end
        ivalid = 1'b0;
        do_reset();
        check("lit_halt_cleared", {31'd0, halted}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
